register_file_nreg: RTL and testbench
=====================================

Name: register_file_nreg

Overview:
Parametrised successor to the two-register register file. Provides DEPTH registers of WIDTH bits, one write port and two independently addressed registered read ports. Adds write-to-read bypass, an optional hardwired-zero register 0, out-of-range address protection and a sequential clear engine with a busy flag. Sits in the CPU datapath between writeback and the ALU operand latches.

Parameters:
WIDTH, 32, data width of each register and of all data ports
DEPTH, 8, number of registers (2..256)
ADDR_W, 3, address width; must satisfy 2^ADDR_W >= DEPTH
ZERO_REG, 0, 1 = register 0 always reads 0 and ignores writes

Ports:
clk  input  1  clock; all state changes on rising edge
reset  input  1  asynchronous, active-low reset
Input  input  WIDTH  write data
waddr  input  ADDR_W  write address
WR  input  1  write enable
raddr1  input  ADDR_W  read address, port 1
raddr2  input  ADDR_W  read address, port 2
clr  input  1  single-cycle request to clear all registers
Output1  output  WIDTH  registered read data, port 1
Output2  output  WIDTH  registered read data, port 2
busy  output  1  high while a clear sweep is in progress

Behaviour:
- Reset (reset=0, asynchronous): all registers = 0; Output1 = Output2 = 0; busy = 0; state = IDLE; clear index = 0. Reset overrides everything, including a clear in progress.
- Write: at a rising edge with state IDLE, WR=1, clr=0 and waddr < DEPTH: reg[waddr] <= Input.
  - Write is ignored if waddr >= DEPTH.
  - Write is ignored if ZERO_REG=1 and waddr=0.
- Read: latency is 1 cycle. At each rising edge, OutputN <= value for raddrN:
  - returns Input if the same-edge write is accepted and waddr == raddrN (bypass);
  - otherwise returns reg[raddrN];
  - returns 0 if raddrN >= DEPTH, or if ZERO_REG=1 and raddrN=0.
  - Both ports may read the same address; both receive identical data.
- Clear state machine, two states:
  - IDLE --clr=1--> CLEAR. Set index=0 and busy=1 on the same edge.
  - CLEAR: each edge writes reg[index] <= 0 and increments index. On the edge that clears index DEPTH-1, go to IDLE with busy=0.
  - busy is high for exactly DEPTH cycles. The sweep takes DEPTH edges.
- During CLEAR:
  - WR is ignored and clr is ignored.
  - Reads continue and return current contents. Already-swept entries read 0; unswept entries keep their old value.
  - Bypass is inactive.
- Simultaneous clr=1 and WR=1 in IDLE: clr wins and the write is dropped.
- Widths: no arithmetic on data. The index counter is ADDR_W+1 bits so the DEPTH=2^ADDR_W terminal count does not wrap early.
- No X propagation: unused address decode paths drive 0.

Test Plan:
1. Reset low for 2 cycles with WR=1, Input=567 -> Output1=Output2=0, busy=0, no register written. Release reset, read all addresses -> all 0.
2. Write 567 to reg 3, then 1234 to reg 5 on consecutive edges; raddr1=3, raddr2=5 -> Output1=567, Output2=1234 one cycle after the reads are presented.
3. Bypass: WR=1, waddr=2, Input=0xDEADBEEF, raddr1=2 on the same edge -> Output1=0xDEADBEEF on that edge. Old value of reg 2 is never shown.
4. Clear with defaults (DEPTH=8, regs preloaded with 1..8): pulse clr -> busy high 8 cycles. WR=1 to reg 0 during the sweep is ignored. After busy falls, all regs read 0.
5. Boundaries: ZERO_REG=1, write 99 to reg 0 -> reads 0. DEPTH=6, ADDR_W=3, write to addr 7 -> no register changes and a read of addr 7 returns 0. clr and WR on the same edge -> write dropped, sweep starts.
6. Reset mid-clear: pulse clr, assert reset after 3 cycles -> busy=0 immediately and all regs 0. After release, a normal write/read of 567 to reg 1 works.

Source files
------------

// File: rtl/register_file_nreg.sv
// rtl/register_file_nreg.sv - DEPTH x WIDTH register file, one write port, two registered read ports, clear sweep
module register_file_nreg #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 8,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  Input,
    input  logic [ADDR_W-1:0] waddr,
    input  logic              WR,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    input  logic              clr,
    output logic [WIDTH-1:0]  Output1,
    output logic [WIDTH-1:0]  Output2,
    output logic              busy
);

    typedef enum logic {
        S_IDLE,
        S_CLEAR
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_W  = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] ONE_W   = (ADDR_W + 1)'(1);

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W:0]   r_idx;
    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [WIDTH-1:0]  r_out1;
    logic [WIDTH-1:0]  r_out2;
    logic [WIDTH-1:0]  w_rd1;
    logic [WIDTH-1:0]  w_rd2;
    logic              w_idle;
    logic              w_wr_ok;
    logic              w_last;

    assign w_idle  = (r_state == S_IDLE);
    assign w_last  = (r_idx == LAST_W);
    assign w_wr_ok = w_idle && WR && !clr && ({1'b0, waddr} < DEPTH_W)
                     && !((ZERO_REG != 0) && (waddr == '0));

    assign Output1 = r_out1;
    assign Output2 = r_out2;
    assign busy    = (r_state == S_CLEAR);

    // Out-of-range addresses match no entry and fall through to zero.
    always_comb begin
        w_rd1 = '0;
        w_rd2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (raddr1 == i[ADDR_W-1:0]) w_rd1 = r_mem[i];
            if (raddr2 == i[ADDR_W-1:0]) w_rd2 = r_mem[i];
        end
        if (w_wr_ok && (waddr == raddr1)) w_rd1 = Input;
        if (w_wr_ok && (waddr == raddr2)) w_rd2 = Input;
        if ((ZERO_REG != 0) && (raddr1 == '0)) w_rd1 = '0;
        if ((ZERO_REG != 0) && (raddr2 == '0)) w_rd2 = '0;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (clr) w_next = S_CLEAR;
            S_CLEAR: if (w_last) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_idx  <= '0;
            r_out1 <= '0;
            r_out2 <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            r_out1 <= w_rd1;
            r_out2 <= w_rd2;
            if (r_state == S_CLEAR) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (r_idx == i[ADDR_W:0]) r_mem[i] <= '0;
                end
                r_idx <= r_idx + ONE_W;
            end else begin
                if (clr) r_idx <= '0;
                for (int i = 0; i < DEPTH; i++) begin
                    if (w_wr_ok && (waddr == i[ADDR_W-1:0])) r_mem[i] <= Input;
                end
            end
        end
    end

endmodule

// File: tb/tb_register_file_nreg.sv
// tb/tb_register_file_nreg.sv - two configurations of register_file_nreg checked against a behavioural model
module tb_register_file_nreg;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] Input = '0;
    logic [2:0]  waddr = '0;
    logic        WR = 1'b0;
    logic [2:0]  raddr1 = '0;
    logic [2:0]  raddr2 = '0;
    logic        clr = 1'b0;
    logic [31:0] o1_a, o2_a, o1_b, o2_b;
    logic        busy_a, busy_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    register_file_nreg #(.WIDTH(32), .DEPTH(8), .ADDR_W(3), .ZERO_REG(0)) u_a (
        .clk(clk), .reset(reset), .Input(Input), .waddr(waddr), .WR(WR),
        .raddr1(raddr1), .raddr2(raddr2), .clr(clr),
        .Output1(o1_a), .Output2(o2_a), .busy(busy_a)
    );

    register_file_nreg #(.WIDTH(32), .DEPTH(6), .ADDR_W(3), .ZERO_REG(1)) u_b (
        .clk(clk), .reset(reset), .Input(Input), .waddr(waddr), .WR(WR),
        .raddr1(raddr1), .raddr2(raddr2), .clr(clr),
        .Output1(o1_b), .Output2(o2_b), .busy(busy_b)
    );

    // Model: index 0 = default configuration, index 1 = DEPTH 6 with hardwired zero.
    logic [31:0] m_mem [2][8];
    logic [31:0] m_o1 [2];
    logic [31:0] m_o2 [2];
    bit          m_busy [2];
    int          m_idx [2];
    int          dep [2] = '{8, 6};
    bit          zr [2]  = '{1'b0, 1'b1};

    function automatic logic [31:0] m_rd(int k, int a);
        if (a >= dep[k] || (zr[k] && a == 0)) return 32'd0;
        if (!m_busy[k] && WR && !clr && int'(waddr) == a) return Input;
        return m_mem[k][a];
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < 2; k++) begin
                for (int a = 0; a < 8; a++) m_mem[k][a] = 32'd0;
                m_o1[k] = 32'd0;
                m_o2[k] = 32'd0;
                m_busy[k] = 1'b0;
                m_idx[k] = 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                m_o1[k] = m_rd(k, int'(raddr1));
                m_o2[k] = m_rd(k, int'(raddr2));
                if (m_busy[k]) begin
                    m_mem[k][m_idx[k]] = 32'd0;
                    m_idx[k]++;
                    if (m_idx[k] == dep[k]) m_busy[k] = 1'b0;
                end else if (clr) begin
                    m_busy[k] = 1'b1;
                    m_idx[k] = 0;
                end else if (WR && int'(waddr) < dep[k] && !(zr[k] && waddr == 3'd0)) begin
                    m_mem[k][waddr] = Input;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("a_out1", o1_a, m_o1[0]);
        check("a_out2", o2_a, m_o2[0]);
        check("a_busy", {31'd0, busy_a}, {31'd0, m_busy[0]});
        check("b_out1", o1_b, m_o1[1]);
        check("b_out2", o2_b, m_o2[1]);
        check("b_busy", {31'd0, busy_b}, {31'd0, m_busy[1]});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        WR = 1'b1; waddr = a; Input = d;
        tick();
        WR = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy_a && n < 20) begin
            tick();
            n++;
        end
        check(name, {31'd0, busy_a}, 32'd0);
    endtask

    initial begin
        int cnt;
        // Reset held with a write pending
        reset = 1'b0; WR = 1'b1; waddr = 3'd3; Input = 32'd567;
        tick(); tick();
        check("rst_out1", o1_a, 32'd0);
        check("rst_out2", o2_a, 32'd0);
        check("rst_busy", {31'd0, busy_a}, 32'd0);
        WR = 1'b0;
        reset = 1'b1;
        for (int a = 0; a < 8; a++) begin
            raddr1 = 3'(a); raddr2 = 3'(7 - a);
            tick();
            check("rst_read_all", o1_a, 32'd0);
        end

        // Two writes then read back
        wr(3'd3, 32'd567);
        wr(3'd5, 32'd1234);
        raddr1 = 3'd3; raddr2 = 3'd5;
        tick();
        check("rd_567", o1_a, 32'd567);
        check("rd_1234", o2_a, 32'd1234);

        // Same-edge write bypass
        wr(3'd2, 32'h11111111);
        WR = 1'b1; waddr = 3'd2; Input = 32'hDEADBEEF; raddr1 = 3'd2; raddr2 = 3'd2;
        tick();
        WR = 1'b0;
        check("bypass1", o1_a, 32'hDEADBEEF);
        check("bypass2", o2_a, 32'hDEADBEEF);

        // Clear sweep over preloaded contents
        for (int a = 0; a < 8; a++) wr(3'(a), 32'(a + 1));
        clr = 1'b1;
        tick();
        clr = 1'b0;
        WR = 1'b1; waddr = 3'd0; Input = 32'd77;
        cnt = 0;
        while (busy_a && cnt < 20) begin
            tick();
            cnt++;
        end
        WR = 1'b0;
        check("busy_cycles", 32'(cnt), 32'd8);
        for (int a = 0; a < 8; a++) begin
            raddr1 = 3'(a);
            tick();
            check("after_clear", o1_a, 32'd0);
        end

        // Hardwired zero and out-of-range address on the DEPTH 6 instance
        wr(3'd0, 32'd99);
        raddr1 = 3'd0;
        tick();
        check("zero_reg_b", o1_b, 32'd0);
        check("reg0_a", o1_a, 32'd99);
        wr(3'd7, 32'd55);
        raddr1 = 3'd7; raddr2 = 3'd5;
        tick();
        check("oor_b", o1_b, 32'd0);
        check("oor_b_reg5", o2_b, 32'd0);
        check("addr7_a", o1_a, 32'd55);

        // clr wins over a same-edge write
        WR = 1'b1; clr = 1'b1; waddr = 3'd4; Input = 32'd4444;
        tick();
        WR = 1'b0; clr = 1'b0;
        check("clr_wr_busy", {31'd0, busy_a}, 32'd1);
        wait_idle("clr_wr_idle");
        raddr1 = 3'd4;
        tick();
        check("clr_wr_dropped", o1_a, 32'd0);

        // Reset in the middle of a sweep
        wr(3'd6, 32'd66);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        tick(); tick();
        #2 reset = 1'b0;
        #1;
        check("midrst_busy_a", {31'd0, busy_a}, 32'd0);
        check("midrst_busy_b", {31'd0, busy_b}, 32'd0);
        check("midrst_out1", o1_a, 32'd0);
        tick();
        reset = 1'b1;
        raddr1 = 3'd6;
        tick();
        check("midrst_reg6", o1_a, 32'd0);
        wr(3'd1, 32'd567);
        raddr1 = 3'd1;
        tick();
        check("post_rst_567", o1_a, 32'd567);
        check("post_rst_567_b", o1_b, 32'd567);

        // Randomised traffic
        for (int c = 0; c < 3000; c++) begin
            WR     = 1'($urandom_range(0, 1));
            waddr  = 3'($urandom_range(0, 7));
            raddr1 = 3'($urandom_range(0, 7));
            raddr2 = ($urandom_range(0, 3) == 0) ? waddr : 3'($urandom_range(0, 7));
            Input  = $urandom;
            clr    = ($urandom_range(0, 39) == 0);
            tick();
        end
        WR = 1'b0; clr = 1'b0;
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
